// File: rtl/logic_unit_arbiter.sv
// -----------------------------------------------------------------------------
// logic_unit_arbiter
//
// Two requesters share one WIDTH-bit logic unit (AND / OR / XOR / NOR). The
// result goes through a single output register stage. The grant is made in
// the same cycle as the request, and the result appears one cycle later. One
// result per cycle is possible when the consumer keeps res_ready high.
//
// Handshake semantics:
//   A transfer happens on a rising clk edge where valid and ready are both
//   high. A valid source holds its payload stable until that edge. ready is
//   computed combinationally from the valids, res_valid, res_ready and the
//   priority pointer. It never depends on opcodes or operands.
//
// Configuration macro: LOGIC_ARB_RR_EN
//   defined   : round-robin on conflicts. The requester not named by
//               last_gnt wins, and last_gnt follows each accepted grant.
//   undefined : requester 0 always wins conflicts. There is no last_gnt.
//
// Ports
//   clk, rst_n            clock and asynchronous active-low reset
//   req0_valid/ready      requester 0 handshake
//   req0_op               00 AND, 01 OR, 10 XOR, 11 NOR
//   req0_a, req0_b        requester 0 operands (WIDTH bits)
//   req1_*                the same set of signals for requester 1
//   res_valid/ready       result handshake
//   res_data              registered logic result (WIDTH bits)
//   res_id                index of the requester that produced res_data
// -----------------------------------------------------------------------------
module logic_unit_arbiter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [1:0]       req0_op,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [1:0]       req1_op,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_data,
    output logic             res_id
);

    localparam logic [1:0] OP_AND = 2'b00;
    localparam logic [1:0] OP_OR  = 2'b01;
    localparam logic [1:0] OP_XOR = 2'b10;

    logic             space;
    logic             gnt0;
    logic             gnt1;
    logic             xfer_in;
    logic             sel;
    logic [1:0]       sel_op;
    logic [WIDTH-1:0] sel_a;
    logic [WIDTH-1:0] sel_b;
    logic [WIDTH-1:0] alu_out;

    // The output register can take a new result if it is empty, or if it is
    // being drained on this same edge.
    assign space = ~res_valid | res_ready;

`ifdef LOGIC_ARB_RR_EN
    logic last_gnt;

    // On a conflict, the requester that was not granted last time wins.
    always_comb begin
        gnt0 = req0_valid & (~req1_valid | last_gnt);
        gnt1 = req1_valid & (~req0_valid | ~last_gnt);
    end

    // The pointer moves only when a grant is actually accepted. After
    // reset it is 1, so requester 0 wins the first conflict.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_gnt <= 1'b1;
        end else if (xfer_in) begin
            last_gnt <= sel;
        end
    end
`else
    // Fixed priority: requester 0 always wins a conflict.
    always_comb begin
        gnt0 = req0_valid;
        gnt1 = req1_valid & ~req0_valid;
    end
`endif

    assign req0_ready = space & gnt0;
    assign req1_ready = space & gnt1;
    assign xfer_in    = req0_ready | req1_ready;

    // Operand mux: choose requester 1's operands only when it is granted.
    always_comb begin
        sel    = req1_ready;
        sel_op = req0_op;
        sel_a  = req0_a;
        sel_b  = req0_b;
        if (sel) begin
            sel_op = req1_op;
            sel_a  = req1_a;
            sel_b  = req1_b;
        end
    end

    // The shared logic unit.
    always_comb begin
        alu_out = ~(sel_a | sel_b);
        case (sel_op)
            OP_AND:  alu_out = sel_a & sel_b;
            OP_OR:   alu_out = sel_a | sel_b;
            OP_XOR:  alu_out = sel_a ^ sel_b;
            default: alu_out = ~(sel_a | sel_b);
        endcase
    end

    // Output register. A new result has priority over a drain, so a drain
    // and a load on the same edge keep res_valid high. A drain with no new
    // load clears res_valid only; res_data and res_id keep their values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_valid <= 1'b0;
            res_data  <= '0;
            res_id    <= 1'b0;
        end else if (xfer_in) begin
            res_valid <= 1'b1;
            res_data  <= alu_out;
            res_id    <= sel;
        end else if (res_ready) begin
            res_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_logic_unit_arbiter.sv
module tb_logic_unit_arbiter;

  localparam int W = 32;

  logic         clk;
  logic         rst_n;
  logic         req0_valid;
  logic         req0_ready;
  logic [1:0]   req0_op;
  logic [W-1:0] req0_a;
  logic [W-1:0] req0_b;
  logic         req1_valid;
  logic         req1_ready;
  logic [1:0]   req1_op;
  logic [W-1:0] req1_a;
  logic [W-1:0] req1_b;
  logic         res_valid;
  logic         res_ready;
  logic [W-1:0] res_data;
  logic         res_id;

  int checks;
  int errors;

  logic [W-1:0] held_data;
  logic         held_id;

  logic_unit_arbiter #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_op    (req0_op),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_op    (req1_op),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_data   (res_data),
    .res_id     (res_id)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver tasks
  task automatic drive_req0(input logic v, input logic [1:0] op,
                            input logic [W-1:0] a, input logic [W-1:0] b);
    req0_valid = v;
    req0_op    = op;
    req0_a     = a;
    req0_b     = b;
  endtask

  task automatic drive_req1(input logic v, input logic [1:0] op,
                            input logic [W-1:0] a, input logic [W-1:0] b);
    req1_valid = v;
    req1_op    = op;
    req1_a     = a;
    req1_b     = b;
  endtask

  // Advance one active edge, then move 1 time unit past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive_req0(1'b0, 2'b00, '0, '0);
    drive_req1(1'b0, 2'b00, '0, '0);
    res_ready = 1'b0;
    #12;
    checks++;
    if (res_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_valid got %b exp 0", res_valid);
    end
    checks++;
    if (res_data !== 32'h0) begin
      errors++;
      $display("FAIL reset_data got %h exp 00000000", res_data);
    end
    checks++;
    if (res_id !== 1'b0) begin
      errors++;
      $display("FAIL reset_id got %b exp 0", res_id);
    end
    checks++;
    if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_ready got %b%b exp 00", req0_ready, req1_ready);
    end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_single_or();
    res_ready = 1'b1;
    drive_req0(1'b1, 2'b01, 32'h17F13EE8, 32'hB0997F07);
    #1;
    checks++;
    if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
      errors++;
      $display("FAIL single_grant got %b%b exp 10", req0_ready, req1_ready);
    end
    step();
    drive_req0(1'b0, 2'b00, '0, '0);
    checks++;
    if (res_valid !== 1'b1 || res_data !== 32'hB7F97FEF || res_id !== 1'b0) begin
      errors++;
      $display("FAIL single_or got v%b %h id%b exp v1 b7f97fef id0", res_valid, res_data, res_id);
    end
    // A drain with no new request clears res_valid; data and id hold.
    step();
    checks++;
    if (res_valid !== 1'b0 || res_data !== 32'hB7F97FEF || res_id !== 1'b0) begin
      errors++;
      $display("FAIL drain_hold got v%b %h id%b exp v0 b7f97fef id0", res_valid, res_data, res_id);
    end
  endtask

  task automatic test_conflict();
    // Reset first so that requester 0 wins the first conflict.
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    res_ready = 1'b1;
    drive_req0(1'b1, 2'b01, 32'h513B1052, 32'h0FF1CE25);
    drive_req1(1'b1, 2'b00, 32'hFFFFFFFF, 32'h0000FFFF);
    #1;
    checks++;
    if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
      errors++;
      $display("FAIL conflict_first_grant got %b%b exp 10", req0_ready, req1_ready);
    end
    step();
    checks++;
    if (res_valid !== 1'b1 || res_data !== 32'h5FFBDE77 || res_id !== 1'b0) begin
      errors++;
      $display("FAIL conflict_res0 got v%b %h id%b exp v1 5ffbde77 id0", res_valid, res_data, res_id);
    end
`ifdef LOGIC_ARB_RR_EN
    checks++;
    if (req0_ready !== 1'b0 || req1_ready !== 1'b1) begin
      errors++;
      $display("FAIL conflict_second_grant got %b%b exp 01", req0_ready, req1_ready);
    end
    step();
    checks++;
    if (res_valid !== 1'b1 || res_data !== 32'h0000FFFF || res_id !== 1'b1) begin
      errors++;
      $display("FAIL conflict_res1 got v%b %h id%b exp v1 0000ffff id1", res_valid, res_data, res_id);
    end
    held_data = 32'h0000FFFF;
    held_id   = 1'b1;
`else
    checks++;
    if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
      errors++;
      $display("FAIL conflict_second_grant got %b%b exp 10", req0_ready, req1_ready);
    end
    step();
    checks++;
    if (res_valid !== 1'b1 || res_data !== 32'h5FFBDE77 || res_id !== 1'b0) begin
      errors++;
      $display("FAIL conflict_res_again got v%b %h id%b exp v1 5ffbde77 id0", res_valid, res_data, res_id);
    end
    held_data = 32'h5FFBDE77;
    held_id   = 1'b0;
`endif
  endtask

  task automatic test_backpressure();
    // A result is pending. Hold the consumer off for 3 cycles.
    res_ready = 1'b0;
    drive_req0(1'b1, 2'b10, 32'hF0F0F0F0, 32'hFF00FF00);
    drive_req1(1'b1, 2'b11, 32'h12345678, 32'h0);
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_ready cyc%0d got %b%b exp 00", i, req0_ready, req1_ready);
      end
      checks++;
      if (res_valid !== 1'b1 || res_data !== held_data || res_id !== held_id) begin
        errors++;
        $display("FAIL bp_hold cyc%0d got v%b %h id%b exp v1 %h id%b", i, res_valid, res_data, res_id, held_data, held_id);
      end
      step();
    end
    // Releasing the consumer allows a grant in the same cycle.
    res_ready = 1'b1;
    #1;
    checks++;
    if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
      errors++;
      $display("FAIL bp_release_grant got %b%b exp 10", req0_ready, req1_ready);
    end
    step();
    drive_req0(1'b0, 2'b00, '0, '0);
    drive_req1(1'b0, 2'b00, '0, '0);
    checks++;
    if (res_valid !== 1'b1 || res_data !== 32'h0FF00FF0 || res_id !== 1'b0) begin
      errors++;
      $display("FAIL bp_result got v%b %h id%b exp v1 0ff00ff0 id0", res_valid, res_data, res_id);
    end
    step();
  endtask

  task automatic test_back_to_back();
    res_ready = 1'b1;
    drive_req1(1'b1, 2'b10, 32'hFFFFFFFF, 32'hB0997F07);
    #1;
    checks++;
    if (req1_ready !== 1'b1 || req0_ready !== 1'b0) begin
      errors++;
      $display("FAIL b2b_grant_xor got %b%b exp 01", req0_ready, req1_ready);
    end
    step();
    drive_req1(1'b1, 2'b11, 32'hFFFFFFFF, 32'hB0997F07);
    checks++;
    if (res_valid !== 1'b1 || res_data !== 32'h4F6680F8 || res_id !== 1'b1) begin
      errors++;
      $display("FAIL b2b_xor got v%b %h id%b exp v1 4f6680f8 id1", res_valid, res_data, res_id);
    end
    checks++;
    if (req1_ready !== 1'b1) begin
      errors++;
      $display("FAIL b2b_grant_nor got %b exp 1", req1_ready);
    end
    step();
    drive_req1(1'b0, 2'b00, '0, '0);
    checks++;
    if (res_valid !== 1'b1 || res_data !== 32'h00000000 || res_id !== 1'b1) begin
      errors++;
      $display("FAIL b2b_nor got v%b %h id%b exp v1 00000000 id1", res_valid, res_data, res_id);
    end
    // Requester 0 AND follows after an idle gap.
    step();
    drive_req0(1'b1, 2'b00, 32'hA5A5A5A5, 32'h0FF00FF0);
    step();
    drive_req0(1'b0, 2'b00, '0, '0);
    checks++;
    if (res_valid !== 1'b1 || res_data !== 32'h05A005A0 || res_id !== 1'b0) begin
      errors++;
      $display("FAIL req0_and got v%b %h id%b exp v1 05a005a0 id0", res_valid, res_data, res_id);
    end
    step();
  endtask

  task automatic test_async_reset();
    res_ready = 1'b0;
    drive_req1(1'b1, 2'b01, 32'h00FF0000, 32'h0000000F);
    step();
    drive_req1(1'b0, 2'b00, '0, '0);
    checks++;
    if (res_valid !== 1'b1 || res_data !== 32'h00FF000F || res_id !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset got v%b %h id%b exp v1 00ff000f id1", res_valid, res_data, res_id);
    end
    // Assert reset between edges. Outputs must clear without a clock edge.
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (res_valid !== 1'b0 || res_data !== 32'h0 || res_id !== 1'b0) begin
      errors++;
      $display("FAIL async_reset got v%b %h id%b exp v0 00000000 id0", res_valid, res_data, res_id);
    end
    step();
    #2;
    rst_n = 1'b1;
    res_ready = 1'b1;
    drive_req0(1'b1, 2'b00, 32'hFFFF0000, 32'hFF00FF00);
    drive_req1(1'b1, 2'b00, 32'h1, 32'h1);
    #1;
    checks++;
    if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_grant got %b%b exp 10", req0_ready, req1_ready);
    end
    step();
    drive_req0(1'b0, 2'b00, '0, '0);
    drive_req1(1'b0, 2'b00, '0, '0);
    checks++;
    if (res_valid !== 1'b1 || res_data !== 32'hFF000000 || res_id !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_res got v%b %h id%b exp v1 ff000000 id0", res_valid, res_data, res_id);
    end
    step();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    held_data = '0;
    held_id = 1'b0;
    test_reset();
    test_single_or();
    test_conflict();
    test_backpressure();
    test_back_to_back();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
